// File: rtl/trace_packetizer.sv
// Trace packet generator: turns filtered RAM bus activity into 2-bit-typed packets
// and queues them in a first-word-fall-through FIFO with valid/ready backpressure.
module trace_packetizer #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TS_BITS    = 5,
  parameter int unsigned BURST_BITS = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] CFG_BASE   = 16'h0010
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] filter_a,
  input  logic [DATA_WIDTH-1:0] filter_d,
  input  logic [DATA_WIDTH-1:0] nfilter_d,
  input  logic [1:0]            filter_ublb,
  input  logic                  filter_read,
  input  logic                  filter_write,
  input  logic                  filter_addr_latch,
  input  logic                  filter_strobe,
  input  logic [15:0]           config_addr,
  input  logic [15:0]           config_data,
  input  logic                  config_strobe,
  output logic [1:0]            pkt_type,
  output logic [ADDR_WIDTH-1:0] pkt_payload,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [15:0]           overflow_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CMP_W = (BURST_BITS > 4) ? BURST_BITS : 4;
  localparam logic [ADDR_WIDTH-1:0] TS_MAX = ADDR_WIDTH'((64'd1 << TS_BITS) - 64'd1);

  typedef enum logic [1:0] {
    PKT_ADDR  = 2'b00,
    PKT_READ  = 2'b01,
    PKT_WRITE = 2'b10,
    PKT_TIME  = 2'b11
  } pkt_t;

  logic                  trace_enable, trace_reads, trace_writes;
  logic [3:0]            read_latency, write_latency;
  logic                  cfg_unused;

  always_ff @(posedge mclk) begin
    if (reset) begin
      {trace_writes, trace_reads, trace_enable} <= 3'b111;
      read_latency  <= 4'd4;
      write_latency <= 4'd3;
    end else if (config_strobe) begin
      if (config_addr == CFG_BASE)
        {trace_writes, trace_reads, trace_enable} <= config_data[2:0];
      if (config_addr == CFG_BASE + 16'd1) begin
        read_latency  <= config_data[3:0];
        write_latency <= config_data[7:4];
      end
    end
  end

  assign cfg_unused = ^config_data[15:8];

  logic [BURST_BITS-1:0] burst, burst_next, burst_inc;
  logic [ADDR_WIDTH-1:0] ts_cnt, ts_next, ts_inc, ts_low, remainder;
  logic [3:0]            rd_thresh, wr_thresh;
  logic                  rd_ok, wr_ok;

  // A latency of 0 behaves like 1, so both map to a threshold of 0.
  assign rd_thresh = (read_latency  == 4'd0) ? 4'd0 : read_latency  - 4'd1;
  assign wr_thresh = (write_latency == 4'd0) ? 4'd0 : write_latency - 4'd1;
  assign rd_ok     = CMP_W'(burst) >= CMP_W'(rd_thresh);
  assign wr_ok     = CMP_W'(burst) >= CMP_W'(wr_thresh);

  assign burst_inc = (burst == '1) ? burst : burst + BURST_BITS'(1);
  assign ts_inc    = (ts_cnt == '1) ? ts_cnt : ts_cnt + ADDR_WIDTH'(1);
  assign ts_low    = (ts_cnt > TS_MAX) ? TS_MAX : ts_cnt;
  assign remainder = ts_cnt - ts_low;

  logic                  ev_valid;
  pkt_t                  ev_type;
  logic [ADDR_WIDTH-1:0] ev_payload;

  always_comb begin
    ev_valid   = 1'b0;
    ev_type    = PKT_ADDR;
    ev_payload = '0;
    ts_next    = ts_cnt;
    burst_next = burst;
    if (filter_strobe) begin
      if (filter_addr_latch)
        burst_next = '0;
      else if (filter_read || filter_write)
        burst_next = burst_inc;
      ts_next = ts_inc;
      if (trace_enable) begin
        if (filter_addr_latch) begin
          ev_valid   = 1'b1;
          ev_type    = PKT_ADDR;
          ev_payload = filter_a;
        end else if (filter_write && trace_writes && wr_ok) begin
          ev_valid   = 1'b1;
          ev_type    = PKT_WRITE;
          ev_payload = ADDR_WIDTH'({ts_low[TS_BITS-1:0], filter_ublb, filter_d});
          ts_next    = remainder;
        end else if (filter_read && trace_reads && rd_ok) begin
          ev_valid   = 1'b1;
          ev_type    = PKT_READ;
          ev_payload = ADDR_WIDTH'({ts_low[TS_BITS-1:0], filter_ublb, nfilter_d});
          ts_next    = remainder;
        end else if (burst == BURST_BITS'(1) && remainder != '0) begin
          ev_valid   = 1'b1;
          ev_type    = PKT_TIME;
          ev_payload = ts_cnt;
          ts_next    = '0;
        end
      end
    end
  end

  logic                  gen_valid;
  pkt_t                  gen_type;
  logic [ADDR_WIDTH-1:0] gen_payload;

  always_ff @(posedge mclk) begin
    if (reset) begin
      burst       <= '0;
      ts_cnt      <= '0;
      gen_valid   <= 1'b0;
      gen_type    <= PKT_ADDR;
      gen_payload <= '0;
    end else begin
      burst       <= burst_next;
      ts_cnt      <= ts_next;
      gen_valid   <= ev_valid;
      gen_type    <= ev_type;
      gen_payload <= ev_payload;
    end
  end

  logic [ADDR_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr, count;
  logic                  empty, full, pop, push_ok, drop;
  logic [ADDR_WIDTH+1:0] head;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = !empty && pkt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = gen_valid && (!full || pop);
  assign drop    = gen_valid && !push_ok;

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (drop && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (push_ok)
      mem[wr_ptr[PTR_W-1:0]] <= {gen_type, gen_payload};
  end

  assign head        = mem[rd_ptr[PTR_W-1:0]];
  assign pkt_valid   = !empty;
  assign pkt_type    = empty ? 2'b00 : head[ADDR_WIDTH+1:ADDR_WIDTH];
  assign pkt_payload = empty ? '0 : head[ADDR_WIDTH-1:0];

endmodule
